// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and the blocks that drain it.
package fifo_pkg;

    localparam int FIFO_WIDTH    = 8;
    localparam int MIN_BUF_DEPTH = 2;

    typedef logic [FIFO_WIDTH-1:0] word_t;

    // Pointer width that stays at least 1 bit for depths of 1 or 2.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// Circular buffer of DEPTH entries; depth need not be a power of two.
module stream_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int PTR_W = ptr_w(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a framed valid/ready stream at up to one word per cycle.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 3,
    parameter int PKT_LEN   = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             fifo_valid,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             busy
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int IDX_W = ptr_w(PKT_LEN);

    if (BUF_DEPTH < MIN_BUF_DEPTH || PKT_LEN < 1) begin : g_bad_param
        $error("fifo_stream_reader: BUF_DEPTH must be >= 2 and PKT_LEN >= 1");
    end

    logic             inflight;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   credit;
    logic             handshake;
    logic [IDX_W-1:0] word_idx;

    // Reserve a slot for every read in flight so a landing word never overflows the buffer.
    assign credit     = {1'b0, occ} + (OCC_W + 1)'(inflight);
    assign fifo_rd_en = nrst && en && fifo_valid && (credit < (OCC_W + 1)'(BUF_DEPTH));

    assign out_valid  = (occ != '0);
    assign handshake  = out_valid && out_ready;
    assign out_last   = out_valid && (word_idx == IDX_W'(PKT_LEN - 1));
    assign busy       = out_valid || inflight;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    stream_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .nrst      (nrst),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (handshake),
        .pop_data  (out_data),
        .occ       (occ)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            word_idx <= '0;
            pkt_cnt  <= '0;
        end else if (handshake) begin
            if (out_last) begin
                word_idx <= '0;
                pkt_cnt  <= pkt_cnt + 1'b1;
            end else begin
                word_idx <= word_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomized bench for fifo_stream_reader against a queue-based stream model.
module tb_fifo_stream_reader;

    localparam int WIDTH     = 8;
    localparam int BUF_DEPTH = 3;
    localparam int PKT_LEN   = 4;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             en = 1'b0;
    logic             out_ready = 1'b0;
    logic             fifo_valid;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_data = '0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic [CNT_W-1:0] pkt_cnt;
    logic             busy;

    logic             w_rd_en;
    logic             w_valid;
    logic [7:0]       w_data = '0;
    logic [7:0]       w_out_data;
    logic             w_out_valid;
    logic             w_ready = 1'b1;
    logic             w_out_last;
    logic [3:0]       w_pkt_cnt;
    logic             w_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] fmem [512];
    logic [8:0] ftail = '0;
    logic [8:0] fhead = '0;
    int         w_pushed = 0;
    int         w_popped = 0;
    logic [7:0] exp_q [$];

    int         hs_done = 0;
    int         rd_done = 0;
    int         mon_out;
    int         mon_buf;
    logic       prev_rd = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .nrst(nrst), .en(en), .fifo_valid(fifo_valid), .fifo_rd_en(fifo_rd_en),
        .fifo_data(fifo_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .pkt_cnt(pkt_cnt), .busy(busy)
    );

    fifo_stream_reader #(
        .WIDTH(8), .BUF_DEPTH(3), .PKT_LEN(1), .CNT_W(4)
    ) dut_wrap (
        .clk(clk), .nrst(nrst), .en(en), .fifo_valid(w_valid), .fifo_rd_en(w_rd_en),
        .fifo_data(w_data), .out_data(w_out_data), .out_valid(w_out_valid),
        .out_ready(w_ready), .out_last(w_out_last), .pkt_cnt(w_pkt_cnt), .busy(w_busy)
    );

    // Synchronous FIFO model: registered read data, reset by the same nrst.
    assign fifo_valid = (fhead != ftail);
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fhead     <= '0;
            fifo_data <= '0;
        end else if (fifo_rd_en) begin
            fifo_data <= fmem[fhead];
            fhead     <= fhead + 9'd1;
        end
    end

    assign w_valid = (w_popped != w_pushed);
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            w_popped <= 0;
            w_data   <= '0;
        end else if (w_rd_en) begin
            w_data   <= 8'(w_popped);
            w_popped <= w_popped + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        fmem[ftail] = d;
        ftail = ftail + 9'd1;
        exp_q.push_back(d);
    endtask

    task automatic drain(input string tag, input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // Stream model: words outstanding = reads issued - handshakes; framing from the handshake count.
    always @(negedge clk) begin
        if (!nrst) begin
            hs_done    = 0;
            rd_done    = 0;
            prev_rd    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            mon_out = rd_done - hs_done;
            mon_buf = mon_out - int'(prev_rd);
            check("mon_busy", 32'(busy), 32'(mon_out != 0));
            check("mon_valid", 32'(out_valid), 32'(mon_buf != 0));
            check("mon_rd_rule", 32'(fifo_rd_en), 32'(en && fifo_valid && (mon_out < BUF_DEPTH)));
            check("mon_credit", 32'(mon_out <= BUF_DEPTH), 32'd1);
            check("mon_pkt_cnt", 32'(pkt_cnt), 32'(hs_done / PKT_LEN));
            check("mon_last", 32'(out_last), 32'(out_valid && (hs_done % PKT_LEN == PKT_LEN - 1)));
            if (prev_stall) begin
                check("mon_hold_valid", 32'(out_valid), 32'd1);
                check("mon_hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                check("mon_have_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("mon_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            rd_done    = rd_done + int'(fifo_rd_en);
            hs_done    = hs_done + int'(out_valid && out_ready);
            prev_rd    = fifo_rd_en;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cnt;
        int w_hs;
        bit done;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        nrst = 1'b1;
        @(negedge clk);
        check("post_rst_rd_en", 32'(fifo_rd_en), 32'd0);

        // Full-rate burst of 8 words
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("burst_rd_en", 32'(fifo_rd_en), 32'(i < 8));
            check("burst_valid", 32'(out_valid), 32'(i >= 2 && i < 10));
            if (i >= 2 && i < 10) begin
                check("burst_data", 32'(out_data), 32'(8'h10 + i - 2));
                check("burst_last", 32'(out_last), 32'((i - 2) % 4 == 3));
            end
        end
        check("burst_pkt_cnt", 32'(pkt_cnt), 32'd2);

        // Backpressure: only the buffer's worth of reads goes out
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'(8'h20 + i));
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_cnt++;
        end
        check("bp_reads", 32'(rd_cnt), 32'd3);
        check("bp_rd_en_low", 32'(fifo_rd_en), 32'd0);
        check("bp_head_data", 32'(out_data), 32'h20);
        tick();
        out_ready = 1'b1;
        drain("bp_drain", 100);

        // Random stalls over 100 increasing words
        tick();
        for (int i = 0; i < 100; i++) push_word(8'(8'h40 + i));
        done = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        check("rnd_drain", 32'(done), 32'd1);
        check("rnd_pkt_cnt", 32'(pkt_cnt), 32'd28);

        // Enable gating mid-packet (word_idx is 2 here)
        tick();
        out_ready = 1'b0;
        push_word(8'hA0);
        tick();
        tick();
        tick();
        push_word(8'hA1);
        @(negedge clk);
        check("eg_rd_issued", 32'(fifo_rd_en), 32'd1);
        tick();
        en = 1'b0;
        push_word(8'hA2);
        push_word(8'hA3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("eg_no_rd_stalled", 32'(fifo_rd_en), 32'd0);
        end
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("eg_no_rd_draining", 32'(fifo_rd_en), 32'd0);
        end
        check("eg_left_in_fifo", 32'(exp_q.size()), 32'd2);
        check("eg_pkt_cnt", 32'(pkt_cnt), 32'd29);
        check("eg_idle", 32'(busy), 32'd0);
        tick();
        en = 1'b1;
        drain("eg_drain", 50);

        // Asynchronous reset with occ=2 and a read in flight
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'(8'h60 + i));
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        exp_q.delete();
        ftail = '0;
        tick();
        tick();
        nrst = 1'b1;
        @(negedge clk);
        check("rel_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rel_pkt_cnt", 32'(pkt_cnt), 32'd0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_word(8'(8'h70 + i));
        drain("rel_drain", 50);
        check("rel_pkt_after", 32'(pkt_cnt), 32'd1);

        // pkt_cnt wrap: CNT_W=4, PKT_LEN=1, 17 words
        tick();
        w_pushed = 17;
        w_hs = 0;
        done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("wrap_cnt_track", 32'(w_pkt_cnt), 32'(w_hs % 16));
            check("wrap_last", 32'(w_out_last), 32'(w_out_valid));
            if (w_out_valid && w_ready) begin
                check("wrap_data", 32'(w_out_data), 32'(w_hs));
                w_hs++;
            end
            if (w_hs == 17) begin
                done = 1'b1;
                break;
            end
        end
        check("wrap_done", 32'(done), 32'd1);
        @(negedge clk);
        check("wrap_pkt_cnt", 32'(w_pkt_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
